src_deserializer: RTL and testbench
===================================

SRC_DESERIALIZER -- requirements
Module: src_deserializer

Interface
REQ-001 SHALL have parameter SRC_WIDTH, default `SRC_WIDTH, output packet width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 0, idle cycles before a partial packet is discarded; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_valid  input  1  byte-stream valid.
REQ-006 SHALL have port rx_ready  output  1  byte-stream ready.
REQ-007 SHALL have port rx_data  input  8  byte-stream payload.
REQ-008 SHALL have port src_valid  output  1  packet valid to the network source stage.
REQ-009 SHALL have port src_ready  input  1  packet ready from the network source stage.
REQ-010 SHALL have port src  output  SRC_WIDTH  assembled packet: opcode in MSBs, then charges.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse when a partial packet is discarded.

Function
REQ-012 SHALL use NB = ceil(SRC_WIDTH/8) bytes per packet; NB=1 when SRC_WIDTH<=8.
REQ-013 SHALL define byte accept as rx_valid && rx_ready, and packet transfer as src_valid && src_ready.
REQ-014 SHALL treat bytes as MSB-first: packet = low SRC_WIDTH bits of {byte0, byte1, ..., byte(NB-1)}; excess MSBs of byte0 are discarded.
REQ-015 SHALL keep a shift register of NB-1 bytes and a byte counter cnt in 0..NB-1, separate from the output register (double buffered).
REQ-016 On byte accept with cnt<NB-1: SHALL shift rx_data into the shift register and increment cnt.
REQ-017 On byte accept with cnt==NB-1: SHALL load src with the assembled packet, set src_valid=1 on the next cycle, and set cnt=0.
REQ-018 SHALL drive rx_ready = !(cnt==NB-1 && src_valid && !src_ready), combinationally.
REQ-019 On a simultaneous final-byte accept and packet transfer: SHALL reload src and keep src_valid=1, with no bubble.
REQ-020 On packet transfer with no reload: SHALL clear src_valid on the next cycle.
REQ-021 SHALL hold src stable while src_valid=1 and src_ready=0.
REQ-022 SHALL have latency of 1 cycle from final-byte accept to src_valid; sustained throughput SHALL be 1 packet per NB cycles.
REQ-023 Timeout counter: SHALL clear on every byte accept, and SHALL increment only while cnt!=0, rx_ready=1, and there is no accept.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): SHALL set cnt=0, clear the counter, and pulse timeout_err for one cycle; src and src_valid SHALL be unaffected.
REQ-025 When a byte accept and timeout expiry occur in the same cycle: the accept SHALL win, with no discard and no pulse.
REQ-026 SHALL not advance the timeout counter while rx_ready=0 (backpressure stall is not idle).
REQ-027 SHALL not reorder, drop or duplicate any accepted byte except on a timeout discard.

Reset
REQ-028 On arstn low: SHALL immediately force src_valid=0, src=0, cnt=0, timeout counter=0, shift register=0, timeout_err=0.
REQ-029 SHALL drive rx_ready=1 during and after reset, since it follows REQ-018 with cnt=0.
REQ-030 Reset mid-packet: SHALL discard the partial bytes without a timeout_err pulse; the first byte accepted after release is byte0.

Structure
REQ-031 SHALL put BYTE_WIDTH=8 and the NB computation function in the shared source_config package; the timeout counter width ($clog2(TIMEOUT_CYCLES+1), minimum 1) SHALL remain local.
REQ-032 SHALL be a single module with no sub-module; src connects directly to the network source stage's src/src_valid/src_ready.

Verification
REQ-033 SRC_WIDTH=20, src_ready=1, bytes 0xAB,0xCD,0xEF back-to-back -> src=0xBCDEF, src_valid high exactly 1 cycle after the third accept.
REQ-034 SRC_WIDTH=20, src_ready=0, six bytes 01..06 offered continuously -> first packet 0x10203 held; rx_ready low after the 5th accept; src_ready=1 -> 0x10203 transferred, 6th byte accepted same cycle, next packet 0x40506 with no bubble.
REQ-035 SRC_WIDTH=20, TIMEOUT_CYCLES=4, send 0x11, 4 idle cycles, then 0xAA,0xBB,0xCC -> one timeout_err pulse, output 0xABBCC.
REQ-036 TIMEOUT_CYCLES=4, byte offered on the 4th idle cycle -> no timeout_err, packet assembled from both bytes.
REQ-037 Assert arstn low after 2 of 3 bytes, release, send 0x0F,0x00,0x01 -> src=0xF0001, no timeout_err.
REQ-038 SRC_WIDTH=8 -> each byte becomes one packet, 1-cycle latency; random src_ready stalls over 1000 packets -> scoreboard shows zero loss.

Source files
------------

// File: rtl/source_config_pkg.sv
// Shared byte-stream configuration for the network source stage.
`ifndef SRC_WIDTH
`define SRC_WIDTH 20
`endif

package source_config;

  localparam int BYTE_WIDTH = 8;

  // Bytes needed to carry a packet of the given width; never less than one.
  function automatic int nb_bytes(input int width);
    return (width <= BYTE_WIDTH) ? 1 : (width + BYTE_WIDTH - 1) / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/src_deserializer.sv
// Assembles MSB-first bytes into SRC_WIDTH packets behind a double-buffered output,
// discarding a stalled partial packet after TIMEOUT_CYCLES idle cycles.
`ifndef SRC_WIDTH
`define SRC_WIDTH 20
`endif

module src_deserializer
  import source_config::*;
#(
  parameter int SRC_WIDTH      = `SRC_WIDTH,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [7:0]           rx_data,
  output logic                 src_valid,
  input  logic                 src_ready,
  output logic [SRC_WIDTH-1:0] src,
  output logic                 timeout_err
);

  localparam int NB  = nb_bytes(SRC_WIDTH);
  localparam int SHW = (NB > 1) ? (NB - 1) * BYTE_WIDTH : BYTE_WIDTH;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NB - 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [SHW-1:0]            r_shift;
  logic [CW-1:0]             r_cnt;
  logic [TW-1:0]             r_to;
  logic [SRC_WIDTH-1:0]      r_src;
  logic                      r_src_valid;
  logic                      r_to_err;

  logic [SHW+BYTE_WIDTH-1:0] w_cat;
  logic                      w_last;
  logic                      w_acc;
  logic                      w_xfer;
  logic                      w_idle;
  logic                      w_expire;
  logic                      w_unused_bits;

  // With NB==1 the shift register is never loaded; w_cat then reduces to rx_data.
  assign w_cat         = {r_shift, rx_data};
  assign w_unused_bits = &{1'b0, w_cat};

  assign w_last   = (r_cnt == LAST);
  assign rx_ready = !(w_last && r_src_valid && !src_ready);
  assign w_acc    = rx_valid && rx_ready;
  assign w_xfer   = r_src_valid && src_ready;
  assign w_idle   = (r_cnt != '0) && rx_ready && !w_acc;
  assign w_expire = (TIMEOUT_CYCLES > 0) && w_idle && (r_to == TO_LAST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_to        <= '0;
      r_src       <= '0;
      r_src_valid <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      r_to_err <= 1'b0;
      if (w_acc) begin
        r_to <= '0;
        if (w_last) begin
          r_src       <= w_cat[SRC_WIDTH-1:0];
          r_src_valid <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_shift <= w_cat[SHW-1:0];
          r_cnt   <= r_cnt + 1'b1;
        end
      end else if (w_expire) begin
        r_cnt    <= '0;
        r_to     <= '0;
        r_to_err <= 1'b1;
      end else if (w_idle && (TIMEOUT_CYCLES > 0)) begin
        r_to <= r_to + 1'b1;
      end
      // A same-cycle reload keeps the output valid with no bubble.
      if (w_xfer && !(w_acc && w_last)) r_src_valid <= 1'b0;
    end
  end

  assign src         = r_src;
  assign src_valid   = r_src_valid;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_src_deserializer.sv
// Scoreboard bench: a 20-bit/timeout-4 instance for directed cases and an 8-bit instance for stall soak.
module tb_src_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arstn;

  logic        a_rx_valid, a_rx_ready, a_src_valid, a_src_ready, a_to_err;
  logic [7:0]  a_rx_data;
  logic [19:0] a_src;
  logic        b_rx_valid, b_rx_ready, b_src_valid, b_src_ready, b_to_err;
  logic [7:0]  b_rx_data;
  logic [7:0]  b_src;

  src_deserializer #(.SRC_WIDTH(20), .TIMEOUT_CYCLES(4)) dut_a (
    .clk(clk), .arstn(arstn), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_data(a_rx_data), .src_valid(a_src_valid), .src_ready(a_src_ready),
    .src(a_src), .timeout_err(a_to_err));

  src_deserializer #(.SRC_WIDTH(8), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .arstn(arstn), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_data(b_rx_data), .src_valid(b_src_valid), .src_ready(b_src_ready),
    .src(b_src), .timeout_err(b_to_err));

  int n_tests = 0;
  int n_fail  = 0;
  int a_pulses = 0;
  int b_pulses = 0;
  logic [19:0] qa[$];
  logic [7:0]  qb[$];
  bit b_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_to_err === 1'b1) a_pulses++;
    if (b_to_err === 1'b1) b_pulses++;
    if (a_src_valid && a_src_ready) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_packet: got 0x%0h expected none", a_src);
      end else check("a_packet", a_src, qa.pop_front());
    end
    if (b_src_valid && b_src_ready) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_packet: got 0x%0h expected none", b_src);
      end else check("b_packet", b_src, qb.pop_front());
    end
  end

  task automatic send_a(input logic [7:0] d);
    bit ok = 1'b0;
    a_rx_valid = 1'b1;
    a_rx_data  = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = a_rx_ready;
      @(posedge clk); #1;
    end
    a_rx_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL a_send_timeout: byte 0x%0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic send_b(input logic [7:0] d);
    bit ok = 1'b0;
    b_rx_valid = 1'b1;
    b_rx_data  = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = b_rx_ready;
      if (ok) qb.push_back(d);
      @(posedge clk); #1;
    end
    b_rx_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL b_send_timeout: byte 0x%0h not accepted within 50 cycles", d);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] dir_b [3];
    dir_b[0] = 8'h3C; dir_b[1] = 8'hC3; dir_b[2] = 8'h00;

    arstn = 1'b0;
    a_rx_valid = 1'b0; a_rx_data = '0; a_src_ready = 1'b1;
    b_rx_valid = 1'b0; b_rx_data = '0; b_src_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_src_valid", a_src_valid, 0);
    check("rst_src", a_src, 0);
    check("rst_rx_ready", a_rx_ready, 1);
    check("rst_timeout_err", a_to_err, 0);
    check("rst_b_rx_ready", b_rx_ready, 1);
    arstn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back three bytes, one-cycle latency.
    qa.push_back(20'hBCDEF);
    send_a(8'hAB);
    send_a(8'hCD);
    check("a033_valid_early", a_src_valid, 0);
    send_a(8'hEF);
    check("a033_latency", a_src_valid, 1);
    check("a033_src", a_src, 20'hBCDEF);
    @(posedge clk); #1;
    check("a033_clear", a_src_valid, 0);

    // Output held under backpressure, then transfer plus reload with no bubble.
    a_src_ready = 1'b0;
    qa.push_back(20'h10203);
    qa.push_back(20'h40506);
    fork
      begin
        for (int i = 1; i <= 6; i++) send_a(8'(i));
      end
      begin
        repeat (8) @(posedge clk); #1;
        check("a034_rx_ready_low", a_rx_ready, 0);
        check("a034_held_valid", a_src_valid, 1);
        check("a034_held_src", a_src, 20'h10203);
        a_src_ready = 1'b1;
        @(posedge clk); #1;
        check("a034_nobubble_valid", a_src_valid, 1);
        check("a034_nobubble_src", a_src, 20'h40506);
      end
    join
    @(posedge clk); #1;
    check("a034_clear", a_src_valid, 0);

    // Four idle cycles discard a partial packet.
    p0 = a_pulses;
    qa.push_back(20'hABBCC);
    send_a(8'h11);
    repeat (4) @(posedge clk); #1;
    send_a(8'hAA);
    send_a(8'hBB);
    send_a(8'hCC);
    @(posedge clk); #1;
    check("a035_pulses", a_pulses, p0 + 1);

    // A byte on the fourth idle cycle beats the timeout.
    p0 = a_pulses;
    qa.push_back(20'h23344);
    send_a(8'h22);
    repeat (3) @(posedge clk); #1;
    send_a(8'h33);
    send_a(8'h44);
    @(posedge clk); #1;
    check("a036_pulses", a_pulses, p0);

    // Reset mid-packet drops the partial bytes silently.
    p0 = a_pulses;
    send_a(8'h55);
    send_a(8'h66);
    arstn = 1'b0;
    #1;
    check("a037_rst_valid", a_src_valid, 0);
    check("a037_rst_src", a_src, 0);
    check("a037_rst_rx_ready", a_rx_ready, 1);
    repeat (2) @(posedge clk); #1;
    arstn = 1'b1;
    qa.push_back(20'hF0001);
    send_a(8'h0F);
    send_a(8'h00);
    send_a(8'h01);
    @(posedge clk); #1;
    check("a037_pulses", a_pulses, p0);

    // Byte-wide packets: one-cycle latency, then random output stalls.
    for (int i = 0; i < 3; i++) begin
      send_b(dir_b[i]);
      check("b_latency_valid", b_src_valid, 1);
      check("b_latency_src", b_src, dir_b[i]);
    end
    b_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send_b(8'(i * 37 + 5));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          @(posedge clk); #1;
          b_src_ready = ($urandom_range(0, 2) != 0);
        end
        b_src_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("b_no_timeout", b_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
